// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multicycle RV32I datapath with one unified memory port.
// An external controller sequences the stage registers (PC, OldPC, IR, Data,
// A, B, ALUOut). A small req/ack FSM adds memory wait states and raises stall
// so the controller freezes until the transaction is acknowledged.
// Optional feature macro: DP_PERF_COUNTERS_EN builds cycle/fetch/stall counters;
// without it the perf outputs are tied to zero.
module multicycle_datapath #(
    parameter int              XLEN      = 32,
    parameter int              REG_COUNT = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic            AdrSrc,
    input  logic            MemAccess,
    input  logic            MemWrite,
    input  logic            IRWrite,
    input  logic            RegWrite,
    input  logic [1:0]      ALUSrcA,
    input  logic [1:0]      ALUSrcB,
    input  logic [2:0]      ALUControl,
    input  logic [2:0]      ImmSrc,
    input  logic [1:0]      ResultSrc,
    output logic            zero,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic [31:0]     perf_cycles,
    output logic [31:0]     perf_fetch,
    output logic [31:0]     perf_stall
);

    typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t;

    mem_state_t      mem_state;
    logic [XLEN-1:0] pc, old_pc, ir, data, a, b, alu_out;
    // Storage covers the full 5-bit index space; entries at or above
    // REG_COUNT are never written and read back as zero.
    logic [XLEN-1:0] rf [32];
    logic [XLEN-1:0] lat_addr, lat_wdata;
    logic            lat_we, lat_irw;

    logic [XLEN-1:0] imm_ext, src_a, src_b, alu_result, result, rd1, rd2;
    logic            waiting, mem_done, done_we, done_irw;
    logic [4:0]      rs1, rs2, rd;

    function automatic logic reg_ok(input logic [4:0] idx);
        return (idx != 5'd0) && (int'(idx) < REG_COUNT);
    endfunction

    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign rd     = ir[11:7];
    assign opcode = ir[6:0];
    assign func3  = ir[14:12];
    assign func7  = ir[31:25];

    assign rd1 = reg_ok(rs1) ? rf[rs1] : '0;
    assign rd2 = reg_ok(rs2) ? rf[rs2] : '0;

    // Immediate generator: every format sign-extended from IR[31]
    always_comb begin
        imm_ext = '0;
        case (ImmSrc)
            3'b000:  imm_ext = XLEN'($signed(ir[31:20]));
            3'b001:  imm_ext = XLEN'($signed({ir[31:25], ir[11:7]}));
            3'b010:  imm_ext = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
            3'b011:  imm_ext = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
            3'b100:  imm_ext = XLEN'($signed({ir[31:12], 12'b0}));
            default: imm_ext = '0;
        endcase
    end

    // ALU operand selection
    always_comb begin
        src_a = '0;
        case (ALUSrcA)
            2'b00:   src_a = pc;
            2'b01:   src_a = old_pc;
            2'b10:   src_a = a;
            default: src_a = '0;
        endcase
        src_b = '0;
        case (ALUSrcB)
            2'b00:   src_b = b;
            2'b01:   src_b = imm_ext;
            2'b10:   src_b = XLEN'(4);
            default: src_b = '0;
        endcase
    end

    // ALU: wraparound arithmetic, 0/1 compares, logical right shift
    always_comb begin
        alu_result = '0;
        case (ALUControl)
            3'b000: alu_result = src_a + src_b;
            3'b001: alu_result = src_a - src_b;
            3'b010: alu_result = src_a & src_b;
            3'b011: alu_result = src_a | src_b;
            3'b100: alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'b101: alu_result = src_a ^ src_b;
            3'b110: alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            3'b111: alu_result = src_a >> src_b[4:0];
        endcase
    end

    assign zero = (alu_result == '0);

    // Result bus feeding PC, regfile and the memory address mux
    always_comb begin
        result = alu_out;
        case (ResultSrc)
            2'b00: result = alu_out;
            2'b01: result = data;
            2'b10: result = alu_result;
            2'b11: result = imm_ext;
        endcase
    end

    // While waiting, the latched request drives the port and the live
    // controller inputs are ignored. The store strobe only asserts with a request.
    assign waiting   = (mem_state == MEM_WAIT);
    assign mem_req   = waiting | MemAccess;
    assign mem_addr  = waiting ? lat_addr  : (AdrSrc ? result : pc);
    assign mem_wdata = waiting ? lat_wdata : b;
    assign mem_we    = waiting ? lat_we    : (MemAccess & MemWrite);
    assign stall     = waiting ? ~mem_ack  : (MemAccess & ~mem_ack);
    assign mem_done  = mem_req & mem_ack;
    assign done_we   = waiting ? lat_we    : MemWrite;
    assign done_irw  = waiting ? lat_irw   : IRWrite;

    // Memory handshake: capture an unacknowledged request and hold it until ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_state <= MEM_IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_irw   <= 1'b0;
        end else if (!waiting) begin
            if (MemAccess && !mem_ack) begin
                mem_state <= MEM_WAIT;
                lat_addr  <= mem_addr;
                lat_wdata <= mem_wdata;
                lat_we    <= MemWrite;
                lat_irw   <= IRWrite;
            end
        end else if (mem_ack) begin
            mem_state <= MEM_IDLE;
        end
    end

    // Stage registers: A/B/ALUOut free-run, PC/IR/Data gated by stall and ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            old_pc  <= '0;
            ir      <= '0;
            data    <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
        end else begin
            a       <= rd1;
            b       <= rd2;
            alu_out <= alu_result;
            if (PCWrite && !stall)
                pc <= result;
            if (mem_done && !done_we) begin
                if (done_irw) begin
                    ir     <= mem_rdata;
                    old_pc <= pc;
                end else begin
                    data   <= mem_rdata;
                end
            end
        end
    end

    // Register file write port; x0 and out-of-range indices are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= '0;
        end else if (RegWrite && !stall && reg_ok(rd)) begin
            rf[rd] <= result;
        end
    end

`ifdef DP_PERF_COUNTERS_EN
    logic [31:0] cyc_cnt, fetch_cnt, stall_cnt;

    // Performance counters, all wrapping at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt   <= '0;
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (mem_done && !done_we && done_irw)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (stall)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_cycles = cyc_cnt;
    assign perf_fetch  = fetch_cnt;
    assign perf_stall  = stall_cnt;
`else
    assign perf_cycles = '0;
    assign perf_fetch  = '0;
    assign perf_stall  = '0;
`endif

endmodule
